// File: rtl/cpu_control_seq_pkg.sv
// Shared types for the microcoded control sequencer: opcodes, sequencer
// states and the control word produced by the microcode ROM.
package cpu_ctrl_pkg;

  localparam int FETCH_STEPS = 2;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'(FETCH_STEPS);
  localparam logic [2:0] T3 = 3'(FETCH_STEPS + 1);
  localparam logic [2:0] T4 = 3'(FETCH_STEPS + 2);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // halt requests the HALT state; last marks an instruction's final active step.
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic halt;
    logic last;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_control_seq_if.sv
// Sequencer-to-datapath control interface. master = sequencer side,
// slave = datapath side. All controls are level signals valid for one cycle.
interface cpu_control_seq_if #(parameter int OPW = 4);
  logic           run;
  logic [OPW-1:0] opcode;
  logic           carry_flag;
  logic           zero_flag;
  logic           pc_out, pc_inc, pc_load;
  logic           mar_load, ram_out, ram_load, ir_load, ir_out;
  logic           a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load;
  logic [2:0]     step;
  logic           instr_done;
  logic           halted;
  cpu_ctrl_pkg::state_t state_dbg;

  modport master (
    input  run, opcode, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load,
           step, instr_done, halted, state_dbg
  );

  modport slave (
    output run, opcode, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load,
           step, instr_done, halted, state_dbg
  );
endinterface

// File: rtl/cpu_microcode_rom.sv
// Combinational microcode: maps (opcode, step, flags) to a control word.
// Each step enables at most one bus driver.
module cpu_microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     step,
  input  logic           carry_flag,
  input  logic           zero_flag,
  output ctrl_word_t     cw
);

  always_comb begin
    cw = '0;
    if (step == T0) begin
      cw.pc_out   = 1'b1;
      cw.mar_load = 1'b1;
    end else if (step == T1) begin
      cw.ram_out = 1'b1;
      cw.ir_load = 1'b1;
      cw.pc_inc  = 1'b1;
    end else begin
      case (opcode_t'(opcode))
        OP_LDA, OP_STA: begin
          if (step == T2) begin
            cw.ir_out   = 1'b1;
            cw.mar_load = 1'b1;
          end else if (step == T3) begin
            cw.last = 1'b1;
            if (opcode_t'(opcode) == OP_LDA) begin
              cw.ram_out = 1'b1;
              cw.a_load  = 1'b1;
            end else begin
              cw.a_out    = 1'b1;
              cw.ram_load = 1'b1;
            end
          end
        end
        OP_ADD, OP_SUB: begin
          if (step == T2) begin
            cw.ir_out   = 1'b1;
            cw.mar_load = 1'b1;
          end else if (step == T3) begin
            cw.ram_out = 1'b1;
            cw.b_load  = 1'b1;
          end else if (step == T4) begin
            cw.alu_out    = 1'b1;
            cw.a_load     = 1'b1;
            cw.flags_load = 1'b1;
            cw.alu_sub    = (opcode_t'(opcode) == OP_SUB);
            cw.last       = 1'b1;
          end
        end
        OP_LDI: if (step == T2) begin
          cw.ir_out = 1'b1;
          cw.a_load = 1'b1;
          cw.last   = 1'b1;
        end
        OP_JMP: if (step == T2) begin
          cw.ir_out  = 1'b1;
          cw.pc_load = 1'b1;
          cw.last    = 1'b1;
        end
        // Conditional jumps leave the bus undriven when not taken.
        OP_JC: if (step == T2) begin
          cw.ir_out  = carry_flag;
          cw.pc_load = carry_flag;
          cw.last    = 1'b1;
        end
        OP_JZ: if (step == T2) begin
          cw.ir_out  = zero_flag;
          cw.pc_load = zero_flag;
          cw.last    = 1'b1;
        end
        OP_OUT: if (step == T2) begin
          cw.a_out    = 1'b1;
          cw.out_load = 1'b1;
          cw.last     = 1'b1;
        end
        OP_HLT: if (step == T2) begin
          cw.halt = 1'b1;
          cw.last = 1'b1;
        end
        default: if (step == T2) cw.last = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_seq.sv
// Control sequencer top: IDLE/EXEC/HALT state, micro-step counter and
// gating of the microcode word onto the datapath controls.
module cpu_control_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW       = 4,
  parameter int STEPS     = 5,
  parameter int EARLY_END = 1
) (
  input  logic clk,
  input  logic reset,
  cpu_control_seq_if.master bus
);

  localparam logic [2:0] LAST_T = 3'(STEPS - 1);

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  ctrl_word_t cw;
  logic       last_step;

  cpu_microcode_rom #(.OPW(OPW)) u_rom (
    .opcode     (bus.opcode),
    .step       (step_q),
    .carry_flag (bus.carry_flag),
    .zero_flag  (bus.zero_flag),
    .cw         (cw)
  );

  // The final slot always ends the instruction, whatever the microcode says.
  assign last_step = (step_q == LAST_T) || ((EARLY_END != 0) && cw.last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        step_d = 3'd0;
        if (bus.run) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cw.halt) begin
          state_d = ST_HALT;
          step_d  = 3'd0;
        end else if (last_step) begin
          state_d = bus.run ? ST_EXEC : ST_IDLE;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_HALT: step_d = 3'd0;
      default: begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    bus.pc_out     = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.mar_load   = 1'b0;
    bus.ram_out    = 1'b0;
    bus.ram_load   = 1'b0;
    bus.ir_load    = 1'b0;
    bus.ir_out     = 1'b0;
    bus.a_load     = 1'b0;
    bus.a_out      = 1'b0;
    bus.b_load     = 1'b0;
    bus.alu_out    = 1'b0;
    bus.alu_sub    = 1'b0;
    bus.flags_load = 1'b0;
    bus.out_load   = 1'b0;
    bus.step       = 3'd0;
    bus.instr_done = 1'b0;
    bus.halted     = (state_q == ST_HALT);
    bus.state_dbg  = state_q;
    if (state_q == ST_EXEC) begin
      bus.pc_out     = cw.pc_out;
      bus.pc_inc     = cw.pc_inc;
      bus.pc_load    = cw.pc_load;
      bus.mar_load   = cw.mar_load;
      bus.ram_out    = cw.ram_out;
      bus.ram_load   = cw.ram_load;
      bus.ir_load    = cw.ir_load;
      bus.ir_out     = cw.ir_out;
      bus.a_load     = cw.a_load;
      bus.a_out      = cw.a_out;
      bus.b_load     = cw.b_load;
      bus.alu_out    = cw.alu_out;
      bus.alu_sub    = cw.alu_sub;
      bus.flags_load = cw.flags_load;
      bus.out_load   = cw.out_load;
      bus.step       = step_q;
      bus.instr_done = last_step || cw.halt;
      bus.halted     = cw.halt;
    end
  end

endmodule

// File: tb/tb_cpu_control_seq.sv
// Bench for cpu_control_seq: one instance with EARLY_END=1 and one with
// EARLY_END=0, checked cycle by cycle against a microcode table model.
module tb_cpu_control_seq;

  localparam int W = 20;
  localparam int B_PC_OUT = 19, B_PC_INC = 18, B_PC_LOAD = 17, B_MAR = 16;
  localparam int B_RAM_OUT = 15, B_RAM_LOAD = 14, B_IR_LOAD = 13, B_IR_OUT = 12;
  localparam int B_A_LOAD = 11, B_A_OUT = 10, B_B_LOAD = 9, B_ALU_OUT = 8;
  localparam int B_ALU_SUB = 7, B_FLAGS = 6, B_OUT_LOAD = 5, B_DONE = 4, B_HALT = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs1, obs0;

  cpu_control_seq_if #(.OPW(4)) if1 ();
  cpu_control_seq_if #(.OPW(4)) if0 ();

  cpu_control_seq #(.OPW(4), .STEPS(5), .EARLY_END(1)) dut1 (
    .clk (clk), .reset (reset), .bus (if1)
  );
  cpu_control_seq #(.OPW(4), .STEPS(5), .EARLY_END(0)) dut0 (
    .clk (clk), .reset (reset), .bus (if0)
  );

  assign obs1 = {if1.pc_out, if1.pc_inc, if1.pc_load, if1.mar_load, if1.ram_out,
                 if1.ram_load, if1.ir_load, if1.ir_out, if1.a_load, if1.a_out,
                 if1.b_load, if1.alu_out, if1.alu_sub, if1.flags_load, if1.out_load,
                 if1.instr_done, if1.halted, if1.step};
  assign obs0 = {if0.pc_out, if0.pc_inc, if0.pc_load, if0.mar_load, if0.ram_out,
                 if0.ram_load, if0.ir_load, if0.ir_out, if0.a_load, if0.a_out,
                 if0.b_load, if0.alu_out, if0.alu_sub, if0.flags_load, if0.out_load,
                 if0.instr_done, if0.halted, if0.step};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int last_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 3;
      4'h2, 4'h3: return 4;
      default:    return 2;
    endcase
  endfunction

  function automatic int fin_of(input bit early, input logic [3:0] op);
    if (op == 4'hF) return 2;
    return early ? last_of(op) : 4;
  endfunction

  // Expected outputs for micro-step s of opcode op, straight from the microcode table.
  function automatic logic [W-1:0] model(input logic [3:0] op, input int s,
                                         input logic c, input logic z, input bit early);
    logic [W-1:0] v;
    v = '0;
    case (s)
      0: begin v[B_PC_OUT] = 1'b1; v[B_MAR] = 1'b1; end
      1: begin v[B_RAM_OUT] = 1'b1; v[B_IR_LOAD] = 1'b1; v[B_PC_INC] = 1'b1; end
      2: case (op)
        4'h1, 4'h2, 4'h3, 4'h4: begin v[B_IR_OUT] = 1'b1; v[B_MAR] = 1'b1; end
        4'h5: begin v[B_IR_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; end
        4'h6: begin v[B_IR_OUT] = 1'b1; v[B_PC_LOAD] = 1'b1; end
        4'h7: if (c) begin v[B_IR_OUT] = 1'b1; v[B_PC_LOAD] = 1'b1; end
        4'h8: if (z) begin v[B_IR_OUT] = 1'b1; v[B_PC_LOAD] = 1'b1; end
        4'hE: begin v[B_A_OUT] = 1'b1; v[B_OUT_LOAD] = 1'b1; end
        4'hF: v[B_HALT] = 1'b1;
        default: ;
      endcase
      3: case (op)
        4'h1: begin v[B_RAM_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; end
        4'h2, 4'h3: begin v[B_RAM_OUT] = 1'b1; v[B_B_LOAD] = 1'b1; end
        4'h4: begin v[B_A_OUT] = 1'b1; v[B_RAM_LOAD] = 1'b1; end
        default: ;
      endcase
      4: if (op == 4'h2 || op == 4'h3) begin
        v[B_ALU_OUT] = 1'b1; v[B_A_LOAD] = 1'b1; v[B_FLAGS] = 1'b1;
        v[B_ALU_SUB] = (op == 4'h3);
      end
      default: ;
    endcase
    if (s == fin_of(early, op)) v[B_DONE] = 1'b1;
    v[2:0] = 3'(s);
    return v;
  endfunction

  function automatic logic [W-1:0] halt_vec();
    logic [W-1:0] v;
    v = '0;
    v[B_HALT] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_cycle(input bit sel, input string tag);
    logic [W-1:0] obs, exp;
    logic [4:0]   drv;
    @(negedge clk);
    obs = sel ? obs1 : obs0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s dut%0d obs=%h exp=%h", tag, sel, obs, exp);
      end
    end
    drv = {obs[B_PC_OUT], obs[B_RAM_OUT], obs[B_IR_OUT], obs[B_A_OUT], obs[B_ALU_OUT]};
    n_cmp++;
    assert ($countones(drv) <= 1 && !(obs[B_PC_INC] && obs[B_PC_LOAD]) && obs[2:0] <= 3'd4)
    else begin
      n_err++;
      $error("FAIL %s_invariant dut%0d obs=%h drivers=%b", tag, sel, obs, drv);
    end
  endtask

  task automatic drive_ops(input bit sel, input logic [3:0] op, input logic c, input logic z);
    if (sel) begin if1.opcode = op; if1.carry_flag = c; if1.zero_flag = z; end
    else     begin if0.opcode = op; if0.carry_flag = c; if0.zero_flag = z; end
  endtask

  task automatic drive_run(input bit sel, input logic r);
    if (sel) if1.run = r;
    else     if0.run = r;
  endtask

  // Entered one cycle before T0; opcode is changed only after T0 so the
  // previous instruction's end decision is not disturbed.
  task automatic run_instr(input bit sel, input logic [3:0] op, input logic c,
                           input logic z, input logic run_after);
    int fin;
    fin = fin_of(sel, op);
    for (int s = 0; s <= fin; s++) begin
      push(model(op, s, c, z, sel));
      check_cycle(sel, $sformatf("op%h_t%0d", op, s));
      if (s == 0) drive_ops(sel, op, c, z);
      if (s == fin) drive_run(sel, run_after);
    end
  endtask

  task automatic reset_to_idle(input bit sel, input logic run_after);
    reset = 1'b1;
    push('0);
    check_cycle(sel, "reset_idle");
    reset = 1'b0;
    drive_run(sel, run_after);
  endtask

  task automatic random_run(input bit sel, input int n);
    logic [3:0] op;
    logic       c, z, ra;
    drive_run(sel, 1'b1);
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      ra = (i != n - 1);
      if (op == 4'hF) begin
        run_instr(sel, op, c, z, 1'b1);
        push(halt_vec());
        check_cycle(sel, "rand_halt");
        reset_to_idle(sel, ra);
      end else begin
        run_instr(sel, op, c, z, ra);
      end
    end
    push('0);
    check_cycle(sel, "rand_end_idle");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    if1.run = 1'b0; if1.opcode = 4'h0; if1.carry_flag = 1'b0; if1.zero_flag = 1'b0;
    if0.run = 1'b0; if0.opcode = 4'h0; if0.carry_flag = 1'b0; if0.zero_flag = 1'b0;
    @(negedge clk);
    push('0); check_cycle(1'b1, "reset");
    push('0); check_cycle(1'b0, "reset_e0");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push('0); check_cycle(1'b1, "idle");
    end

    drive_run(1'b1, 1'b1);
    run_instr(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
    run_instr(1'b1, 4'h8, 1'b0, 1'b1, 1'b1);
    run_instr(1'b1, 4'h8, 1'b1, 1'b0, 1'b1);
    run_instr(1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 4'hB, 1'b1, 1'b1, 1'b1);
    // run dropped during the last step of LDA
    run_instr(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    push('0); check_cycle(1'b1, "idle_after_drop");
    push('0); check_cycle(1'b1, "idle_hold");

    // reset arriving during T1
    drive_run(1'b1, 1'b1);
    push(model(4'h1, 0, 1'b0, 1'b0, 1'b1)); check_cycle(1'b1, "pre_reset_t0");
    push(model(4'h1, 1, 1'b0, 1'b0, 1'b1)); check_cycle(1'b1, "pre_reset_t1");
    reset_to_idle(1'b1, 1'b1);

    run_instr(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      push(halt_vec());
      check_cycle(1'b1, "halt_hold");
      drive_run(1'b1, 1'($urandom_range(0, 1)));
    end
    reset_to_idle(1'b1, 1'b0);
    push('0); check_cycle(1'b1, "idle_after_halt");

    random_run(1'b1, 1000);
    random_run(1'b0, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
